// File: rtl/regfile_sweeper.sv
// regfile_sweeper: bulk FILL / DUMP sequencer that borrows the register-file
// write port and both read ports while the core is held.
module regfile_sweeper #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] fill_base,
  input  logic [DATA_W-1:0] fill_step,
  output logic              busy,
  output logic              done,
  output logic              rf_regwr,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_data,
  output logic [ADDR_W-1:0] rf_ra,
  output logic [ADDR_W-1:0] rf_rb,
  input  logic [DATA_W-1:0] rf_outa,
  input  logic [DATA_W-1:0] rf_outb,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_valid,
  input  logic              dout_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DUMP_RD,
    S_DUMP_A,
    S_DUMP_B,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NREGS - 2);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   step_q, step_d;
  logic [DATA_W-1:0]   bufb_q, bufb_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rf_regwr_q, rf_regwr_d;
  logic [ADDR_W-1:0]   rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0]   rf_data_q, rf_data_d;
  logic [ADDR_W-1:0]   rf_ra_q, rf_ra_d;
  logic [ADDR_W-1:0]   rf_rb_q, rf_rb_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [ADDR_W-1:0]   dout_idx_q, dout_idx_d;
  logic                dout_valid_q, dout_valid_d;

  // Next-state logic; every output is computed for the upcoming state so it leaves a flop.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    step_d       = step_q;
    bufb_d       = bufb_q;
    done_d       = 1'b0;
    rf_regwr_d   = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_data_d    = rf_data_q;
    rf_ra_d      = rf_ra_q;
    rf_rb_d      = rf_rb_q;
    dout_d       = dout_q;
    dout_idx_d   = dout_idx_q;
    dout_valid_d = dout_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d  = '0;
          acc_d  = fill_base;
          step_d = fill_step;
          if (mode) begin
            state_d = S_DUMP_RD;
            rf_ra_d = '0;
            rf_rb_d = ADDR_W'(1);
          end else begin
            state_d    = S_FILL;
            rf_regwr_d = 1'b1;
            rf_rd_d    = '0;
            rf_data_d  = fill_base;
          end
        end
      end

      S_FILL: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d      = idx_q + ADDR_W'(1);
          acc_d      = acc_q + step_q;
          rf_regwr_d = 1'b1;
          rf_rd_d    = idx_q + ADDR_W'(1);
          rf_data_d  = acc_q + step_q;
        end
      end

      S_DUMP_RD: begin
        // The even register goes straight to dout; the odd one waits in bufb.
        dout_d       = rf_outa;
        bufb_d       = rf_outb;
        dout_idx_d   = idx_q;
        dout_valid_d = 1'b1;
        state_d      = S_DUMP_A;
      end

      S_DUMP_A: begin
        if (dout_ready) begin
          dout_d     = bufb_q;
          dout_idx_d = idx_q + ADDR_W'(1);
          state_d    = S_DUMP_B;
        end
      end

      S_DUMP_B: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          if (idx_q == LAST_PAIR) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + ADDR_W'(2);
            rf_ra_d = idx_q + ADDR_W'(2);
            rf_rb_d = idx_q + ADDR_W'(3);
            state_d = S_DUMP_RD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      step_q       <= '0;
      bufb_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rf_regwr_q   <= 1'b0;
      rf_rd_q      <= '0;
      rf_data_q    <= '0;
      rf_ra_q      <= '0;
      rf_rb_q      <= '0;
      dout_q       <= '0;
      dout_idx_q   <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      step_q       <= step_d;
      bufb_q       <= bufb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rf_regwr_q   <= rf_regwr_d;
      rf_rd_q      <= rf_rd_d;
      rf_data_q    <= rf_data_d;
      rf_ra_q      <= rf_ra_d;
      rf_rb_q      <= rf_rb_d;
      dout_q       <= dout_d;
      dout_idx_q   <= dout_idx_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rf_regwr   = rf_regwr_q;
  assign rf_rd      = rf_rd_q;
  assign rf_data    = rf_data_q;
  assign rf_ra      = rf_ra_q;
  assign rf_rb      = rf_rb_q;
  assign dout       = dout_q;
  assign dout_idx   = dout_idx_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_regfile_sweeper.sv
// tb_regfile_sweeper: drives FILL/DUMP commands into regfile_sweeper with an
// attached register-file model and checks every cycle against a transaction model.
module tb_regfile_sweeper;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] fill_base;
  logic [DATA_W-1:0] fill_step;
  logic              busy;
  logic              done;
  logic              rf_regwr;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] rf_ra;
  logic [ADDR_W-1:0] rf_rb;
  logic [DATA_W-1:0] rf_outa;
  logic [DATA_W-1:0] rf_outb;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W-1:0] dout_idx;
  logic              dout_valid;
  logic              dout_ready;

  regfile_sweeper #(
    .NREGS (NREGS),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .fill_base (fill_base),
    .fill_step (fill_step),
    .busy      (busy),
    .done      (done),
    .rf_regwr  (rf_regwr),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .rf_ra     (rf_ra),
    .rf_rb     (rf_rb),
    .rf_outa   (rf_outa),
    .rf_outb   (rf_outb),
    .dout      (dout),
    .dout_idx  (dout_idx),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file attached to the sweeper: synchronous write, combinational reads.
  logic [DATA_W-1:0] rf_mem [NREGS];
  assign rf_outa = rf_mem[rf_ra];
  assign rf_outb = rf_mem[rf_rb];
  always @(posedge clk) begin
    if (rf_regwr) rf_mem[rf_rd] <= rf_data;
  end

  // Transaction model state
  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
  } item_t;

  item_t             m_q[$];
  logic [DATA_W-1:0] ref_mem [NREGS];
  bit                m_active;
  bit                m_dump;
  bit                m_gap;
  bit                m_done_now;
  bit                m_done_next;
  int                m_accept_cyc;
  int                m_done_cyc;
  int                cyc;
  int                done_pulses;
  int                regwr_cycles;
  int                words_seen;
  int                word7_stalls;

  int                n_checks;
  int                n_errors;

  int                ready_mode;
  int                stall_cnt;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},       64'(busy),       64'd0);
    checkOutput({tag, "_done"},       64'(done),       64'd0);
    checkOutput({tag, "_rf_regwr"},   64'(rf_regwr),   64'd0);
    checkOutput({tag, "_rf_rd"},      64'(rf_rd),      64'd0);
    checkOutput({tag, "_rf_data"},    64'(rf_data),    64'd0);
    checkOutput({tag, "_rf_ra"},      64'(rf_ra),      64'd0);
    checkOutput({tag, "_rf_rb"},      64'(rf_rb),      64'd0);
    checkOutput({tag, "_dout"},       64'(dout),       64'd0);
    checkOutput({tag, "_dout_idx"},   64'(dout_idx),   64'd0);
    checkOutput({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
  endtask

  // Per-cycle comparison against the transaction model, sampled mid-cycle.
  always @(negedge clk) begin
    bit                idle_now;
    bit                exp_regwr;
    bit                exp_valid;
    int                last_idx;
    logic [DATA_W-1:0] k;
    item_t             it;
    cyc++;
    if (!rst_n) begin
      checkAllZero("reset");
      m_q.delete();
      m_active    = 1'b0;
      m_gap       = 1'b0;
      m_done_now  = 1'b0;
      m_done_next = 1'b0;
    end else begin
      m_done_now  = m_done_next;
      m_done_next = 1'b0;
      idle_now    = !m_active && !m_done_now;
      exp_regwr   = m_active && !m_dump;
      exp_valid   = m_active && m_dump && !m_gap;
      if (m_done_now) m_done_cyc = cyc;
      if (done) done_pulses++;
      if (dout_valid && dout_idx == ADDR_W'(7) && !dout_ready) word7_stalls++;

      checkOutput("done",       64'(done),       64'(m_done_now));
      checkOutput("busy",       64'(busy),       64'(m_active || m_done_now));
      checkOutput("rf_regwr",   64'(rf_regwr),   64'(exp_regwr));
      checkOutput("dout_valid", 64'(dout_valid), 64'(exp_valid));

      if (exp_regwr) begin
        regwr_cycles++;
        checkOutput("fill_rd",   64'(rf_rd),   64'(m_q[0].idx));
        checkOutput("fill_data", 64'(rf_data), 64'(m_q[0].data));
        ref_mem[m_q[0].idx] = m_q[0].data;
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_active    = 1'b0;
          m_done_next = 1'b1;
        end
      end else if (m_active && m_dump) begin
        if (m_gap) begin
          checkOutput("dump_ra", 64'(rf_ra), 64'(m_q[0].idx));
          checkOutput("dump_rb", 64'(rf_rb), 64'(m_q[0].idx + 1));
          m_gap = 1'b0;
        end else begin
          checkOutput("dump_dout",     64'(dout),     64'(m_q[0].data));
          checkOutput("dump_dout_idx", 64'(dout_idx), 64'(m_q[0].idx));
          if (dout_ready) begin
            last_idx = m_q[0].idx;
            void'(m_q.pop_front());
            words_seen++;
            if (last_idx % 2 == 1) begin
              if (m_q.size() == 0) begin
                m_active    = 1'b0;
                m_done_next = 1'b1;
              end else begin
                m_gap = 1'b1;
              end
            end
          end
        end
      end

      if (start && idle_now) begin
        m_active     = 1'b1;
        m_dump       = mode;
        m_gap        = mode;
        m_accept_cyc = cyc;
        m_q.delete();
        for (int i = 0; i < NREGS; i++) begin
          k       = DATA_W'(i);
          it.idx  = i;
          it.data = mode ? ref_mem[i] : (fill_base + fill_step * k);
          m_q.push_back(it);
        end
      end
    end
  end

  // Sink ready generator: always ready, toggling with a stall on word 7, or random.
  initial begin
    bit tog;
    tog        = 1'b0;
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tog = ~tog;
      case (ready_mode)
        0: dout_ready = 1'b1;
        1: begin
          if (dout_valid && dout_idx == ADDR_W'(7) && stall_cnt < 5) begin
            dout_ready = 1'b0;
            stall_cnt++;
          end else begin
            dout_ready = tog;
          end
        end
        default: dout_ready = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  task automatic waitIdle(input string name, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (!m_active && !m_done_now && !m_done_next) return;
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: still busy after %0d cycles, required idle", name, budget);
  endtask

  task automatic applyStimulus(input logic m, input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] s);
    @(posedge clk);
    #1;
    start     = 1'b1;
    mode      = m;
    fill_base = b;
    fill_step = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic runCommand(input logic m, input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] s);
    waitIdle("pre_cmd_idle", 400);
    applyStimulus(m, b, s);
    waitIdle("cmd_complete", 400);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed and randomized sequence
  initial begin
    int p0, r0, w0, s0;
    logic [DATA_W-1:0] expv;
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    ready_mode = 0;
    stall_cnt  = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    fill_base  = '0;
    fill_step  = '0;
    for (int i = 0; i < NREGS; i++) begin
      rf_mem[i]  = 32'hA5A5_0000 | DATA_W'(i);
      ref_mem[i] = 32'hA5A5_0000 | DATA_W'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // FILL base=2 step=1
    p0 = done_pulses; r0 = regwr_cycles;
    runCommand(1'b0, 32'd2, 32'd1);
    checkOutput("fill2_regwr_cycles", 64'(regwr_cycles - r0), 64'd32);
    checkOutput("fill2_done_pulses", 64'(done_pulses - p0), 64'd1);
    checkOutput("fill2_latency", 64'(m_done_cyc - m_accept_cyc), 64'd33);
    checkOutput("fill2_busy_after", 64'(busy), 64'd0);
    for (int i = 0; i < NREGS; i++) begin
      checkOutput("fill2_reg", 64'(rf_mem[i]), 64'(i + 2));
    end

    // DUMP with ready tied high
    w0 = words_seen; p0 = done_pulses;
    runCommand(1'b1, 32'd0, 32'd0);
    checkOutput("dump_words", 64'(words_seen - w0), 64'd32);
    checkOutput("dump_latency", 64'(m_done_cyc - m_accept_cyc), 64'd49);
    checkOutput("dump_done_pulses", 64'(done_pulses - p0), 64'd1);

    // DUMP with toggling ready and a 5-cycle stall on word 7
    ready_mode = 1; stall_cnt = 0;
    w0 = words_seen; s0 = word7_stalls;
    runCommand(1'b1, 32'd0, 32'd0);
    checkOutput("stall_words", 64'(words_seen - w0), 64'd32);
    checkOutput("stall_word7", 64'((word7_stalls - s0) >= 5), 64'd1);
    ready_mode = 0;

    // FILL wrapping around 2^32
    runCommand(1'b0, 32'hFFFF_FFFF, 32'd1);
    checkOutput("wrap_reg0", 64'(rf_mem[0]), 64'h0000_0000_FFFF_FFFF);
    checkOutput("wrap_reg1", 64'(rf_mem[1]), 64'h0);
    checkOutput("wrap_reg31", 64'(rf_mem[31]), 64'h1E);

    // start with mode=1 during FILL is ignored
    waitIdle("ign_pre_idle", 400);
    p0 = done_pulses; r0 = regwr_cycles;
    applyStimulus(1'b0, 32'd100, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; mode = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitIdle("ign_complete", 400);
    checkOutput("ign_done_pulses", 64'(done_pulses - p0), 64'd1);
    checkOutput("ign_regwr_cycles", 64'(regwr_cycles - r0), 64'd32);
    checkOutput("ign_reg0", 64'(rf_mem[0]), 64'd100);
    checkOutput("ign_reg31", 64'(rf_mem[31]), 64'd193);

    // Reset in FILL cycle 10
    waitIdle("rstf_pre_idle", 400);
    applyStimulus(1'b0, 32'h5000, 32'h10);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst_fill");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      expv = (i < 10) ? (32'h5000 + 32'h10 * DATA_W'(i)) : (32'd100 + 32'd3 * DATA_W'(i));
      checkOutput("rst_fill_reg", 64'(rf_mem[i]), 64'(expv));
    end
    runCommand(1'b0, 32'h1234_0000, 32'h0000_0101);
    runCommand(1'b1, 32'd0, 32'd0);

    // Reset mid-DUMP; the next DUMP restarts from register 0
    waitIdle("rstd_pre_idle", 400);
    applyStimulus(1'b1, 32'd0, 32'd0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_dout_valid", 64'(dout_valid), 64'd0);
    checkAllZero("async_rst_dump");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = words_seen;
    runCommand(1'b1, 32'd0, 32'd0);
    checkOutput("rstd_words", 64'(words_seen - w0), 64'd32);

    // Randomized FILL/DUMP pairs with random sink back-pressure
    ready_mode = 2;
    for (int it = 0; it < 6; it++) begin
      runCommand(1'b0, $urandom, $urandom);
      runCommand(1'b1, $urandom, $urandom);
    end
    ready_mode = 0;
    waitIdle("final_idle", 400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
